// File: rtl/matmul_pkg.sv
// matmul_pkg: shared widths, size limit and sequencer state encoding
package matmul_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 20;
  localparam int DEF_ADDR_W = 8;
  localparam int MAX_N      = 15;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, FLUSH, WRITE, DONE, HOLD} state_t;
endpackage

// File: rtl/matmul_sequencer_mac_unit.sv
// mac_unit: registered unsigned multiply-accumulate, restarting on the first term of a dot product
module mac_unit #(
  parameter int DATA_W = matmul_pkg::DEF_DATA_W,
  parameter int ACC_W  = matmul_pkg::DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              clear_first,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_d, acc_q;
  // full-width product, zero-extended into the accumulator
  always_comb begin
    prod  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    acc_d = valid ? (clear_first ? '0 : acc_q) + {{(ACC_W-2*DATA_W){1'b0}}, prod} : acc_q;
  end
  // accumulator register
  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks i/j/k over an NxN multiply, issuing operand reads and one result write per element
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        size,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr,
  output logic [ACC_W-1:0]  c_data,
  output logic              busy,
  output logic              done
);
  state_t state_d, state_q;
  logic [3:0] n_d, n_q, i_d, i_q, j_d, j_q, k_d, k_q;
  logic [ADDR_W-1:0] row_d, row_q, kn_d, kn_q, n_w;
  logic rd_en_d, rd_en_q, c_we_d, c_we_q, busy_d, busy_q, done_d, done_q;
  logic vld_d, vld_q, first_d, first_q;
  logic [ADDR_W-1:0] a_addr_d, a_addr_q, b_addr_d, b_addr_q, c_addr_d, c_addr_q;
  assign n_w = {{(ADDR_W-4){1'b0}}, n_q};
  // next state and index counters; row_q tracks i*N and kn_q tracks k*N by repeated addition
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    row_d = row_q;
    kn_d = kn_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        n_d = size;
        i_d = '0;
        j_d = '0;
        k_d = '0;
        row_d = '0;
        kn_d = '0;
      end
      LOAD: state_d = (n_q == 4'd0) ? DONE : ISSUE;
      ISSUE: if (k_q == n_q - 4'd1) begin
        state_d = FLUSH;
        k_d = '0;
        kn_d = '0;
      end else begin
        k_d = k_q + 4'd1;
        kn_d = kn_q + n_w;
      end
      FLUSH: state_d = WRITE;
      WRITE: begin
        state_d = ISSUE;
        if (j_q == n_q - 4'd1) begin
          j_d = '0;
          i_d = i_q + 4'd1;
          row_d = row_q + n_w;
          if (i_q == n_q - 4'd1) state_d = DONE;
        end else j_d = j_q + 4'd1;
      end
      DONE: state_d = HOLD;
      HOLD: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are precomputed from the next state so every port comes straight from a flop
  always_comb begin
    rd_en_d  = state_d == ISSUE;
    c_we_d   = state_d == WRITE;
    busy_d   = state_d != IDLE;
    done_d   = state_d == DONE;
    a_addr_d = row_d + {{(ADDR_W-4){1'b0}}, k_d};
    b_addr_d = kn_d + {{(ADDR_W-4){1'b0}}, j_d};
    c_addr_d = row_d + {{(ADDR_W-4){1'b0}}, j_d};
    vld_d    = rd_en_q;
    first_d  = rd_en_q && k_q == 4'd0;
  end
  // state, counter and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      row_q <= '0;
      kn_q <= '0;
      rd_en_q <= 1'b0;
      c_we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      vld_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      row_q <= row_d;
      kn_q <= kn_d;
      rd_en_q <= rd_en_d;
      c_we_q <= c_we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      vld_q <= vld_d;
      first_q <= first_d;
    end
  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .rst(rst),
    .valid(vld_q),
    .clear_first(first_q),
    .a(a_data),
    .b(b_data),
    .acc(c_data)
  );
  assign rd_en  = rd_en_q;
  assign c_we   = c_we_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign a_addr = a_addr_q;
  assign b_addr = b_addr_q;
  assign c_addr = c_addr_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: scoreboard bench with operand RAM models and a plain-arithmetic matrix product reference
module tb_matmul_sequencer;
  logic clk = 1'b0, rst, start;
  logic [3:0] size;
  logic rd_en, c_we, busy, done;
  logic [7:0] a_addr, b_addr, c_addr, a_data, b_data;
  logic [19:0] c_data;
  logic [7:0] amem [0:255];
  logic [7:0] bmem [0:255];
  typedef struct { int addr; int data; } exp_t;
  exp_t exp_q[$];
  int passed = 0, total = 0, we_cnt = 0, rd_cnt = 0;

  matmul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
    .c_we(c_we), .c_addr(c_addr), .c_data(c_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) begin
    a_data <= amem[a_addr];
    b_data <= bmem[b_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rd_en) rd_cnt++;
    if (!rst && c_we) begin
      we_cnt++;
      if (exp_q.size() == 0) chk("unexpected_c_we", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("c_addr", c_addr, e.addr);
        chk("c_data", c_data, e.data);
      end
    end
  end

  task automatic fill(input int n, input int mode);
    for (int x = 0; x < n * n; x++) begin
      amem[x] = (mode == 1) ? 8'd255 : 8'($urandom);
      bmem[x] = (mode == 1) ? 8'd255 : 8'($urandom);
    end
  endtask

  task automatic model(input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        exp_t e;
        e.addr = i * n + j;
        e.data = 0;
        for (int k = 0; k < n; k++) e.data += int'(amem[i * n + k]) * int'(bmem[k * n + j]);
        exp_q.push_back(e);
      end
  endtask

  task automatic cyc1();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input int n, input int hold, input bit drop_mid);
    int cyc, done_cyc, we0, rd0, rd1;
    model(n);
    we0 = we_cnt;
    rd0 = rd_cnt;
    @(negedge clk);
    size = 4'(n);
    start = 1'b1;
    cyc = 0;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < 5000) begin
      cyc1();
      cyc++;
      if (cyc == 2) size = 4'($urandom);
      if (drop_mid && cyc == 3) start = 1'b0;
      if (n == 0) chk("n0_busy", busy, 1);
      if (done) done_cyc = cyc;
    end
    chk("done_cycle", done_cyc, 2 + n * n * (n + 2));
    cyc1();
    chk("done_pulse", done, 0);
    chk("hold_busy", busy, 1);
    rd1 = rd_cnt;
    repeat (hold) cyc1();
    if (hold > 0) begin
      chk("hold_no_reads", rd_cnt - rd1, 0);
      chk("hold_still_busy", busy, 1);
    end
    start = 1'b0;
    cyc1();
    cyc1();
    chk("idle_busy", busy, 0);
    chk("write_count", we_cnt - we0, n * n);
    chk("read_count", rd_cnt - rd0, n * n * n);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic reset_test();
    int we0, we1;
    fill(3, 0);
    model(3);
    we0 = we_cnt;
    @(negedge clk);
    size = 4'd3;
    start = 1'b1;
    repeat (18) cyc1();
    chk("pre_reset_writes", we_cnt - we0, 3);
    chk("pre_reset_rd_en", rd_en, 1);
    chk("pre_reset_a_addr", a_addr, 4);
    chk("pre_reset_b_addr", b_addr, 3);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {rd_en, c_we, busy, done, a_addr, b_addr, c_addr, c_data}, 0);
    exp_q.delete();
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    we1 = we_cnt;
    repeat (10) cyc1();
    chk("no_write_after_reset", we_cnt - we1, 0);
    chk("idle_after_reset", busy, 0);
    fill(3, 0);
    run_op(3, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    size = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_en, c_we, busy, done, a_addr, b_addr, c_addr, c_data}, 0);
    rst = 1'b0;
    amem[0] = 8'd1; amem[1] = 8'd2; amem[2] = 8'd3; amem[3] = 8'd4;
    bmem[0] = 8'd5; bmem[1] = 8'd6; bmem[2] = 8'd7; bmem[3] = 8'd8;
    run_op(2, 0, 0);
    run_op(0, 0, 0);
    fill(1, 1);
    run_op(1, 0, 0);
    fill(1, 0);
    run_op(1, 40, 0);
    fill(1, 0);
    run_op(1, 0, 0);
    fill(15, 1);
    run_op(15, 0, 0);
    for (int t = 0; t < 4; t++) begin
      int n;
      n = int'($urandom_range(1, 6));
      fill(n, 0);
      run_op(n, 0, t[0]);
    end
    reset_test();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
